// File: rtl/cfg_loader_pkg.sv
// rtl/cfg_loader_pkg.sv - shared types and sizing helpers for the config chain loader
package cfg_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SHIFT  = 3'd2,
    COMMIT = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Width of a counter that must hold every value 0..chain_len inclusive
  function automatic int cnt_w(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction

  // Number of words needed to cover the whole chain
  function automatic int nwords(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  // Width of a per-word bit index that can also hold word_w itself
  function automatic int idx_w(input int word_w);
    return $clog2(word_w + 1);
  endfunction

endpackage

// File: rtl/cfg_rb_capture.sv
// rtl/cfg_rb_capture.sv - serial-to-word readback capture with a single holding slot
module cfg_rb_capture
  import cfg_loader_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int IDX_W  = idx_w(WORD_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample,
  input  logic              bit_in,
  input  logic [IDX_W-1:0]  idx,
  input  logic              last,
  input  logic              rb_ready,
  output logic              rb_valid,
  output logic [WORD_W-1:0] rb_data,
  output logic              stall
);

  logic [WORD_W-1:0] cap_q;
  logic [WORD_W-1:0] cap_next;

  // Capture word with the current bit merged in; bits above idx stay zero,
  // which pads a short final word.
  always_comb begin
    cap_next = cap_q | (WORD_W'(bit_in) << idx);
  end

  // A completing shift needs the slot; hold the shifter off while it is
  // occupied and not being drained this cycle.
  assign stall = last & rb_valid & ~rb_ready;

  // Accumulate bits, hand finished words to the slot, release the slot on handshake
  always_ff @(posedge clk) begin
    if (!rst) begin
      cap_q    <= '0;
      rb_valid <= 1'b0;
      rb_data  <= '0;
    end else begin
      if (sample && last) begin
        rb_data  <= cap_next;
        rb_valid <= 1'b1;
        cap_q    <= '0;
      end else begin
        if (sample) begin
          cap_q <= cap_next;
        end
        if (rb_valid && rb_ready) begin
          rb_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/config_chain_loader.sv
// rtl/config_chain_loader.sv - streams config words serially into a connection-block chain
module config_chain_loader
  import cfg_loader_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rb_en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WORD_W-1:0] cfg_data,
  output logic              rb_valid,
  input  logic              rb_ready,
  output logic [WORD_W-1:0] rb_data,
  output logic              cen,
  output logic              shift_in,
  input  logic              shift_out,
  output logic              set_in,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = cnt_w(CHAIN_LEN);
  localparam int IDX_W = idx_w(WORD_W);
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(CHAIN_LEN);

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [IDX_W-1:0]  word_idx;
  logic [IDX_W-1:0]  word_bits;
  logic [WORD_W-1:0] sreg;
  logic              rb_en_q;

  logic              last_bit;
  logic              final_bit;
  logic              stall;
  logic              shift_now;
  logic [31:0]       remain;

  // Decode the current shift position and whether this cycle may shift
  always_comb begin
    last_bit  = (word_idx == word_bits - IDX_W'(1));
    final_bit = (bit_cnt == LEN_C - CNT_W'(1));
    shift_now = (state == SHIFT) && !(rb_en_q && stall);
    remain    = 32'(LEN_C - bit_cnt);
  end

  assign cen      = shift_now;
  assign shift_in = shift_now & sreg[0];

  cfg_rb_capture #(
    .WORD_W (WORD_W),
    .IDX_W  (IDX_W)
  ) u_capture (
    .clk      (clk),
    .rst      (rst),
    .sample   (shift_now & rb_en_q),
    .bit_in   (shift_out),
    .idx      (word_idx),
    .last     (last_bit),
    .rb_ready (rb_ready),
    .rb_valid (rb_valid),
    .rb_data  (rb_data),
    .stall    (stall)
  );

  // Load FSM: fetch a word, shift its useful bits out LSB-first, commit once the chain is full
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      word_idx  <= '0;
      word_bits <= '0;
      sreg      <= '0;
      rb_en_q   <= 1'b0;
      cfg_ready <= 1'b0;
      set_in    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      set_in <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= LOAD;
            rb_en_q   <= rb_en;
            bit_cnt   <= '0;
            cfg_ready <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        LOAD: begin
          if (cfg_valid && cfg_ready) begin
            sreg      <= cfg_data;
            word_idx  <= '0;
            word_bits <= (remain >= 32'(WORD_W)) ? IDX_W'(WORD_W) : IDX_W'(remain);
            cfg_ready <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (shift_now) begin
            sreg     <= sreg >> 1;
            word_idx <= word_idx + IDX_W'(1);
            if (bit_cnt != LEN_C) begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (last_bit) begin
              if (final_bit) begin
                state  <= COMMIT;
                set_in <= 1'b1;
              end else begin
                state     <= LOAD;
                cfg_ready <= 1'b1;
              end
            end
          end
        end
        COMMIT: begin
          if (!rb_valid || rb_ready) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_chain_loader.sv
// tb/tb_config_chain_loader.sv - directed self-checking bench for config_chain_loader
module tb_config_chain_loader;

  localparam int WORD_W    = 4;
  localparam int CHAIN_LEN = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              rb_en = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [WORD_W-1:0] cfg_data = '0;
  logic              rb_valid;
  logic              rb_ready = 1'b1;
  logic [WORD_W-1:0] rb_data;
  logic              cen;
  logic              shift_in;
  logic              shift_out;
  logic              set_in;
  logic              busy;
  logic              done;

  config_chain_loader #(
    .WORD_W    (WORD_W),
    .CHAIN_LEN (CHAIN_LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rb_en     (rb_en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .rb_valid  (rb_valid),
    .rb_ready  (rb_ready),
    .rb_data   (rb_data),
    .cen       (cen),
    .shift_in  (shift_in),
    .shift_out (shift_out),
    .set_in    (set_in),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Behavioural 10-bit chain: bits enter at the top, leave from bit 0
  logic [CHAIN_LEN-1:0] chain = '0;
  logic [CHAIN_LEN-1:0] preload_val = '0;
  logic                 preload_req = 1'b0;
  assign shift_out = chain[0];

  always @(posedge clk) begin
    if (preload_req) chain <= preload_val;
    else if (cen) chain <= {shift_in, chain[CHAIN_LEN-1:1]};
  end

  int checks = 0;
  int failures = 0;

  int cen_cnt, set_cnt, set_at, busy_cyc, bad_si, viol;
  logic [CHAIN_LEN-1:0] shift_seq;
  logic [WORD_W-1:0] rb_q[$];

  // Observe the interface mid-cycle
  always @(negedge clk) begin
    if (busy) busy_cyc++;
    if (!cen && shift_in) bad_si++;
    if (cen) begin
      if (cen_cnt < CHAIN_LEN) shift_seq[cen_cnt] = shift_in;
      if (rb_valid && !rb_ready && (cen_cnt == 3 || cen_cnt == 7 || cen_cnt == 9)) viol++;
      cen_cnt++;
    end
    if (set_in) begin
      set_cnt++;
      set_at = cen_cnt;
    end
    if (rb_valid && rb_ready) rb_q.push_back(rb_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    cen_cnt = 0; set_cnt = 0; set_at = 0; busy_cyc = 0; bad_si = 0; viol = 0;
    shift_seq = '0;
    rb_q.delete();
  endtask

  task automatic preload(input logic [CHAIN_LEN-1:0] v);
    @(posedge clk); #1;
    preload_val = v; preload_req = 1'b1;
    @(posedge clk); #1;
    preload_req = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) break;
    end
    check(tag, {31'b0, done}, 32'd1);
  endtask

  task automatic run_load(input logic [3:0] w0, input logic [3:0] w1, input logic [3:0] w2,
                          input int gap, input bit rbe, input bit do_start, input string tag);
    logic [3:0] w[3];
    bit ok;
    w[0] = w0; w[1] = w1; w[2] = w2;
    if (do_start) begin
      @(posedge clk); #1;
      start = 1'b1; rb_en = rbe;
      @(posedge clk); #1;
      start = 1'b0; rb_en = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        if (cfg_ready) begin ok = 1'b1; break; end
      end
      if (!ok) begin
        check({tag, "_cfg_ready_timeout"}, 32'd0, 32'd1);
        return;
      end
      repeat (gap) @(negedge clk);
      cfg_valid = 1'b1; cfg_data = w[i];
      @(posedge clk); #1;
      cfg_valid = 1'b0;
    end
    wait_done({tag, "_done"});
  endtask

  task automatic check_rb(input string tag);
    logic [3:0] exp_rb[3];
    exp_rb[0] = 4'hB; exp_rb[1] = 4'hA; exp_rb[2] = 4'h2;
    check({tag, "_rb_count"}, rb_q.size(), 32'd3);
    for (int i = 0; i < 3; i++)
      check({tag, "_rb_word"}, (i < rb_q.size()) ? {28'b0, rb_q[i]} : 32'hDEAD, {28'b0, exp_rb[i]});
  endtask

  int saved_cen;

  initial begin
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {25'b0, cfg_ready, rb_valid, cen, set_in, busy, done, shift_in}, 32'd0);
    check("reset_rb_data", {28'b0, rb_data}, 32'd0);
    rst = 1'b1;

    // 1: plain load, no readback
    clear_stats();
    run_load(4'hA, 4'h5, 4'h3, 0, 1'b0, 1'b1, "t1");
    check("t1_shift_seq", {22'b0, shift_seq}, 32'h35A);
    check("t1_cen_cnt", cen_cnt, 32'd10);
    check("t1_set_cnt", set_cnt, 32'd1);
    check("t1_set_after_last", set_at, 32'd10);
    check("t1_busy_cycles", busy_cyc, 32'd14);
    check("t1_busy_low", {31'b0, busy}, 32'd0);
    check("t1_chain", {22'b0, chain}, 32'h35A);
    check("t1_no_rb", rb_q.size(), 32'd0);
    check("t1_shift_in_gated", bad_si, 32'd0);

    // 2: readback of a preloaded chain
    preload(10'h2AB);
    clear_stats();
    run_load(4'hA, 4'h5, 4'h3, 0, 1'b1, 1'b1, "t2");
    check_rb("t2");
    check("t2_chain", {22'b0, chain}, 32'h35A);
    check("t2_busy_cycles", busy_cyc, 32'd14);

    // 3: readback backpressure for 20 cycles
    preload(10'h2AB);
    clear_stats();
    fork
      run_load(4'hA, 4'h5, 4'h3, 0, 1'b1, 1'b1, "t3");
      begin
        repeat (3) @(posedge clk);
        #1 rb_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1 rb_ready = 1'b1;
      end
    join
    check_rb("t3");
    check("t3_chain", {22'b0, chain}, 32'h35A);
    check("t3_no_overrun", viol, 32'd0);
    check("t3_cen_cnt", cen_cnt, 32'd10);
    check("t3_set_cnt", set_cnt, 32'd1);

    // 4: gaps of 3 cycles on the config stream
    preload(10'h000);
    clear_stats();
    run_load(4'hA, 4'h5, 4'h3, 3, 1'b0, 1'b1, "t4");
    check("t4_chain", {22'b0, chain}, 32'h35A);
    check("t4_cen_cnt", cen_cnt, 32'd10);
    check("t4_busy_cycles", busy_cyc, 32'd23);
    check("t4_shift_in_gated", bad_si, 32'd0);

    // 5: reset in the middle of a load
    clear_stats();
    @(posedge clk); #1;
    start = 1'b1; cfg_valid = 1'b1; cfg_data = 4'hF;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (cen_cnt >= 5) break;
    end
    check("t5_reached_5", {31'b0, (cen_cnt >= 5)}, 32'd1);
    rst = 1'b0;
    cfg_valid = 1'b0;
    @(posedge clk); #1;
    check("t5_reset_outs", {25'b0, cfg_ready, rb_valid, cen, set_in, busy, done, shift_in}, 32'd0);
    check("t5_reset_rb_data", {28'b0, rb_data}, 32'd0);
    rst = 1'b1;
    saved_cen = cen_cnt;
    repeat (5) @(posedge clk);
    #1;
    check("t5_no_more_shift", cen_cnt, saved_cen);
    check("t5_no_set_in", set_cnt, 32'd0);
    clear_stats();
    run_load(4'h6, 4'h9, 4'h1, 0, 1'b0, 1'b1, "t5b");
    check("t5_chain", {22'b0, chain}, 32'h196);
    check("t5_set_cnt", set_cnt, 32'd1);

    // 6: start while busy is ignored, start in DONE restarts
    clear_stats();
    fork
      run_load(4'hA, 4'h5, 4'h3, 0, 1'b0, 1'b1, "t6");
      begin
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    join
    check("t6_chain", {22'b0, chain}, 32'h35A);
    check("t6_busy_cycles", busy_cyc, 32'd14);
    check("t6_set_cnt", set_cnt, 32'd1);
    clear_stats();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("t6_restart", {29'b0, done, busy, cfg_ready}, 32'b011);
    run_load(4'hC, 4'hC, 4'hC, 0, 1'b0, 1'b0, "t6b");
    check("t6b_chain", {22'b0, chain}, 32'h0CC);
    check("t6b_cen_cnt", cen_cnt, 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
